sm_regdump_uart: RTL and testbench
==================================

Name: sm_regdump_uart

Overview:
Board-side initiator for the CPU register-readout interface. The CPU side is a responder: it takes a register address and returns that register's data.
- On a start pulse, the block walks register addresses 0..REG_COUNT-1 and samples each register's data.
- Each register is transmitted as one ASCII line over a UART 8N1 serial output, so the whole register file can be dumped to a host terminal.
- The block sits in the top level beside the register-readout path and runs on the board input clock.

Parameters:
BAUD_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
REG_COUNT, 32, number of registers dumped, addresses 0..REG_COUNT-1; legal range 1..32
SETTLE, 2, clk cycles between changing regAddr and sampling regData; minimum 1

Ports:
clk       input   1   system clock; all logic on posedge
rst       input   1   asynchronous, active-high reset
start     input   1   single-cycle request to begin a dump; honoured only in IDLE
regAddr   output  5   register address driven to the CPU register-readout port
regData   input   32  register data returned for regAddr
tx        output  1   UART serial output; idles high
busy      output  1   high from the cycle after an accepted start until done
done      output  1   one-cycle pulse after the last stop bit of the last line

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: tx=1, busy=0, done=0, regAddr=0, FSM=IDLE, baud counter=0, character index=0.
- Reset mid-operation: tx returns high immediately (asynchronously). Any frame in progress is abandoned with no further bits sent.
- Line format, 13 characters per register, sent in this order:
  - two uppercase hex digits of the address;
  - ':' (0x3A);
  - eight uppercase hex digits of the data, most significant nibble first;
  - CR (0x0D), then LF (0x0A).
- Hex mapping: nibble 0-9 -> 0x30-0x39; nibble A-F -> 0x41-0x46.
- Address field: the 5-bit address is zero-extended to 8 bits before hex conversion.
- UART frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly BAUD_DIV cycles; one character takes 10*BAUD_DIV cycles.
- Character spacing: back-to-back, with no idle gap between characters or between lines.
- FSM states and transitions:
  - IDLE: on start=1 -> SETUP with regAddr=0 and busy=1.
  - SETUP: hold regAddr for SETUP cycles (SETTLE), then -> LATCH.
  - LATCH: capture regData into a 32-bit data register and regAddr into an address register (1 cycle), then -> SEND. Later changes on regData do not affect the line being sent.
  - SEND: serialise the 13 characters via the byte transmitter.
    - After LF of a non-final register: regAddr increments and -> SETUP.
    - After LF of register REG_COUNT-1: -> FIN.
  - FIN: done=1 for one cycle, busy=0 and regAddr=0 in that same cycle, then -> IDLE.
- start while busy: ignored, not queued. start asserted on the same cycle done pulses: ignored; the next start in IDLE is accepted.
- Latencies:
  - start (cycle 0) -> busy=1 at cycle 1.
  - First start-bit falling edge on tx at cycle 1+SETTLE+1+1.
  - Total dump: REG_COUNT*(SETTLE+2+13*10*BAUD_DIV) cycles, ±2 for FSM overhead. The ±2 window is the only timing tolerance; all other latencies are exact.
- Arithmetic: regAddr increments by 1 with no wrap. The dump terminates before address REG_COUNT is ever driven. The baud counter is 16 bits, counting 0..BAUD_DIV-1.

Decomposition:
- Shared package, sm_regdump_pkg:
  - FSM state enumeration;
  - character constants (COLON, CR, LF);
  - LINE_LEN=13;
  - hex-to-ASCII function.
- Sub-module sm_uart_tx: byte transmitter with a valid/ready handshake.
  - Byte accepted on valid&&ready.
  - ready is low from acceptance until the end of the stop bit.
  - ready rises in the same cycle as the last stop-bit cycle ends, so the next byte starts with no gap.
  - Owns the baud counter, the bit counter and tx.
- Top FSM: owns address stepping, data latching and the character index/mux.

Test Plan:
- Reset idle: assert rst for 3 cycles, then release with no start for 100 cycles -> tx=1, busy=0, done=0, regAddr=0 throughout.
- Single-register frame: BAUD_DIV=4, REG_COUNT=2, regfile model reg0=0x00000000, reg1=0xDEADBEEF; pulse start -> UART monitor decodes "00:00000000\r\n01:DEADBEEF\r\n". Each bit is exactly 4 cycles; done pulses once; busy falls with done.
- Full dump: REG_COUNT=32, regN=N*0x01010101 -> 32 lines. Line 31 reads "1F:1F1F1F1F\r\n". Total cycle count is within the ±2 window of the formula. regAddr never exceeds 31.
- Data stability: change regData for the current address in the middle of the SEND state -> the transmitted line carries the value captured at LATCH.
- start while busy: pulse start again in the middle of line 5 -> no restart and no extra lines; exactly one done pulse.
- Reset mid-character: assert rst during data bit 3 of line 2 -> tx=1 within the same cycle. After release, a new start produces a full dump beginning at "00:".

Source files
------------

// File: rtl/sm_regdump_pkg.sv
// Shared definitions for the register-dump UART initiator.
// Contents:
//   - FSM state encoding constants (IDLE, SETUP, LATCH, SEND, FIN)
//   - ASCII constants for the line punctuation
//   - LINE_LEN: characters per register line ("AA:DDDDDDDD\r\n")
//   - hex_ascii(): maps a 4-bit nibble to its uppercase ASCII hex digit
package sm_regdump_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_LATCH = 3'd2;
    localparam state_t ST_SEND  = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    localparam int LINE_LEN = 13;

    // 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/sm_regdump_uart_tx.sv
// Byte transmitter, UART 8N1, with a valid/ready handshake.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   valid     - a byte is offered on data
//   data      - byte to send (LSB first)
//   ready     - transmitter can take a byte this cycle; also high during the
//               final cycle of a stop bit so frames run back-to-back
//   tx        - serial output, idles high
module sm_uart_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam logic [15:0] BAUD_M1  = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  STOP_BIT = 4'd9;

    logic        active;
    logic [3:0]  bit_cnt;
    logic [15:0] baud_cnt;
    logic [8:0]  shreg;
    logic        bit_end;
    logic        accept;

    assign bit_end = (baud_cnt == BAUD_M1);
    assign ready   = !active || (bit_end && (bit_cnt == STOP_BIT));
    assign accept  = valid && ready;

    // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
        end else if (accept) begin
            active   <= 1'b1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == STOP_BIT) begin
                    active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shreg[0];
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

    // Stop bit sits above the data so the ninth shift presents it on tx.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= {1'b1, data};
        end else if (active && bit_end && (bit_cnt != STOP_BIT)) begin
            shreg <= {1'b1, shreg[8:1]};
        end
    end

endmodule

// File: rtl/sm_regdump_uart.sv
// Register-file dump over UART.  On start, walks addresses 0..REG_COUNT-1 on
// the CPU register-readout port and sends one line "AA:DDDDDDDD\r\n" per
// register, back-to-back, over a UART 8N1 output.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   start    - one-cycle dump request, honoured only when idle
//   regAddr  - address presented to the register-readout port
//   regData  - data returned for regAddr
//   tx       - UART serial output (idles high)
//   busy     - dump in progress
//   done     - one-cycle pulse once the last line has been fully sent
module sm_regdump_uart
    import sm_regdump_pkg::*;
#(
    parameter int BAUD_DIV  = 434,
    parameter int REG_COUNT = 32,
    parameter int SETTLE    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0]  LAST_ADDR = 5'(REG_COUNT - 1);
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);
    localparam logic [3:0]  LINE_END  = 4'(LINE_LEN);

    state_t      state;
    logic [15:0] settle_cnt;
    logic [3:0]  char_idx;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic [7:0]  char_sel;
    logic [2:0]  nib_sel;
    logic        tx_valid;
    logic        tx_ready;

    assign done     = (state == ST_FIN);
    assign tx_valid = (state == ST_SEND) && (char_idx != LINE_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            char_idx   <= '0;
            regAddr    <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SETUP;
                        settle_cnt <= '0;
                        regAddr    <= '0;
                        busy       <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (settle_cnt == SETTLE_M1) begin
                        settle_cnt <= '0;
                        state      <= ST_LATCH;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                ST_LATCH: begin
                    char_idx <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    // With char_idx == LINE_END, tx_ready marks the final
                    // cycle of the LF stop bit: the line is on the wire.
                    if (tx_ready) begin
                        if (char_idx != LINE_END) begin
                            char_idx <= char_idx + 4'd1;
                        end else begin
                            char_idx <= '0;
                            if (regAddr == LAST_ADDR) begin
                                state   <= ST_FIN;
                                busy    <= 1'b0;
                                regAddr <= '0;
                            end else begin
                                regAddr <= regAddr + 5'd1;
                                state   <= ST_SETUP;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Snapshot so the line being sent is immune to later regData changes.
    always_ff @(posedge clk) begin
        if (state == ST_LATCH) begin
            data_q <= regData;
            addr_q <= regAddr;
        end
    end

    // Characters 3..10 carry data nibbles 7..0.
    always_comb begin
        nib_sel  = 3'(4'd10 - char_idx);
        char_sel = CHAR_LF;
        case (char_idx)
            4'd0:    char_sel = hex_ascii({3'b000, addr_q[4]});
            4'd1:    char_sel = hex_ascii(addr_q[3:0]);
            4'd2:    char_sel = CHAR_COLON;
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:
                     char_sel = hex_ascii(data_q[{nib_sel, 2'b00} +: 4]);
            4'd11:   char_sel = CHAR_CR;
            default: char_sel = CHAR_LF;
        endcase
    end

    sm_uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .valid (tx_valid),
        .data  (char_sel),
        .ready (tx_ready),
        .tx    (tx)
    );

endmodule

// File: tb/tb_sm_regdump_uart.sv
module tb_sm_regdump_uart;

    localparam int BAUD_A = 4;
    localparam int RC_A   = 2;
    localparam int BAUD_B = 3;
    localparam int RC_B   = 32;
    localparam int SET    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [4:0]  regAddr_a, regAddr_b;
    logic [31:0] regData_a, regData_b;
    logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    logic [31:0] regs_a [32];
    logic [31:0] regs_b [32];

    assign regData_a = regs_a[regAddr_a];
    assign regData_b = regs_b[regAddr_b];

    always #5 clk = ~clk;

    sm_regdump_uart #(.BAUD_DIV(BAUD_A), .REG_COUNT(RC_A), .SETTLE(SET)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .regAddr(regAddr_a),
        .regData(regData_a), .tx(tx_a), .busy(busy_a), .done(done_a));

    sm_regdump_uart #(.BAUD_DIV(BAUD_B), .REG_COUNT(RC_B), .SETTLE(SET)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .regAddr(regAddr_b),
        .regData(regData_b), .tx(tx_b), .busy(busy_b), .done(done_b));

    int tests = 0;
    int fails = 0;
    string HEXS = "0123456789ABCDEF";

    logic [7:0] rx_a[$], rx_b[$], exp_a[$], exp_b[$];
    int done_cnt_a = 0, done_cnt_b = 0, max_addr_b = 0;

    // ---------------- UART receiver model (one per DUT) ----------------
    int         mon_cyc [2];
    bit         mon_act [2];
    logic [9:0] mon_bits[2];
    bit         mon_bad [2];
    logic       mt;
    int         mbd, mbit;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mt  = (d == 0) ? tx_a : tx_b;
            mbd = (d == 0) ? BAUD_A : BAUD_B;
            if (rst) begin
                mon_act[d] = 1'b0;
            end else begin
                if (!mon_act[d] && mt === 1'b0) begin
                    mon_act[d] = 1'b1;
                    mon_cyc[d] = 0;
                    mon_bad[d] = 1'b0;
                end
                if (mon_act[d]) begin
                    mbit = mon_cyc[d] / mbd;
                    if (mon_cyc[d] % mbd == 0) mon_bits[d][mbit] = mt;
                    else if (mt !== mon_bits[d][mbit]) mon_bad[d] = 1'b1;
                    if (mon_cyc[d] == 10 * mbd - 1) begin
                        tests++;
                        if (mon_bad[d] || mon_bits[d][0] !== 1'b0 || mon_bits[d][9] !== 1'b1) begin
                            fails++;
                            $display("FAIL frame dut%0d: bits(stop..start) %b unsteady=%0d, required start 0, stop 1, each bit %0d cycles",
                                     d, mon_bits[d], mon_bad[d], mbd);
                        end
                        if (d == 0) rx_a.push_back(mon_bits[d][8:1]);
                        else        rx_b.push_back(mon_bits[d][8:1]);
                        mon_act[d] = 1'b0;
                    end else begin
                        mon_cyc[d]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
        if (busy_b === 1'b1 && int'(regAddr_b) > max_addr_b) max_addr_b = int'(regAddr_b);
    end

    // ---------------- reference model: expected byte stream ----------------
    function automatic logic [7:0] hx(input int n);
        return HEXS[n];
    endfunction

    task automatic push_line(input int d, input int a, input logic [31:0] v);
        logic [7:0] ln[$];
        ln.push_back(hx((a >> 4) & 15));
        ln.push_back(hx(a & 15));
        ln.push_back(8'h3A);
        for (int k = 7; k >= 0; k--) ln.push_back(hx(int'((v >> (4 * k)) & 32'hF)));
        ln.push_back(8'h0D);
        ln.push_back(8'h0A);
        foreach (ln[i]) begin
            if (d == 0) exp_a.push_back(ln[i]);
            else        exp_b.push_back(ln[i]);
        end
    endtask

    task automatic build_exp(input int d);
        if (d == 0) begin
            exp_a.delete();
            for (int a = 0; a < RC_A; a++) push_line(0, a, regs_a[a]);
        end else begin
            exp_b.delete();
            for (int a = 0; a < RC_B; a++) push_line(1, a, regs_b[a]);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic cmp_stream(input string nm, input int d);
        logic [7:0] g[$];
        logic [7:0] e[$];
        int bad_i;
        if (d == 0) begin g = rx_a; e = exp_a; end
        else        begin g = rx_b; e = exp_b; end
        bad_i = -1;
        for (int i = 0; i < e.size() && i < g.size(); i++)
            if (bad_i < 0 && g[i] !== e[i]) bad_i = i;
        if (bad_i < 0 && g.size() != e.size())
            bad_i = (g.size() < e.size()) ? g.size() : e.size();
        tests++;
        if (bad_i >= 0) begin
            fails++;
            $display("FAIL %s: first difference at byte %0d, got %02h required %02h (%0d bytes received, %0d required)",
                     nm, bad_i, (bad_i < g.size()) ? g[bad_i] : 8'h00,
                     (bad_i < e.size()) ? e[bad_i] : 8'h00, g.size(), e.size());
        end
    endtask

    // Leaves the caller at the negedge of cycle 1 (the cycle after start is sampled).
    task automatic pulse_start(input int d);
        @(negedge clk);
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit, output int cyc);
        logic dn;
        cyc = 1;
        dn  = (d == 0) ? done_a : done_b;
        while (dn !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            dn = (d == 0) ? done_a : done_b;
        end
        if (dn !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_done dut%0d: no done within %0d cycles", d, limit);
        end
    endtask

    task automatic wait_rx(input int n, input int limit);
        int c = 0;
        while (rx_b.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        if (rx_b.size() < n) begin
            tests++;
            fails++;
            $display("FAIL wait_rx: %0d bytes received, required %0d", rx_b.size(), n);
        end
    endtask

    // ---------------- vector table for the two-register dump ----------------
    typedef struct {
        int         cyc;
        logic       busy;
        logic       done;
        logic       tx;
        logic [4:0] addr;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    initial begin
        int cyc, ti, bad_a, bad_b, tot;
        string s31;

        // Cycle numbers count from the cycle after start is sampled (= 1).
        // Line 0 char '0' = 0x30: start 5..8, d0-d3 9..24 low, d4-d5 25..32
        // high, d6-d7 33..40 low, stop 41..44, next start bit at 45.
        tbl[0]  = '{1,    1'b1, 1'b0, 1'b1, 5'd0};
        tbl[1]  = '{3,    1'b1, 1'b0, 1'b1, 5'd0};
        tbl[2]  = '{4,    1'b1, 1'b0, 1'b1, 5'd0};
        tbl[3]  = '{5,    1'b1, 1'b0, 1'b0, 5'd0};
        tbl[4]  = '{8,    1'b1, 1'b0, 1'b0, 5'd0};
        tbl[5]  = '{9,    1'b1, 1'b0, 1'b0, 5'd0};
        tbl[6]  = '{21,   1'b1, 1'b0, 1'b0, 5'd0};
        tbl[7]  = '{24,   1'b1, 1'b0, 1'b0, 5'd0};
        tbl[8]  = '{25,   1'b1, 1'b0, 1'b1, 5'd0};
        tbl[9]  = '{32,   1'b1, 1'b0, 1'b1, 5'd0};
        tbl[10] = '{33,   1'b1, 1'b0, 1'b0, 5'd0};
        tbl[11] = '{40,   1'b1, 1'b0, 1'b0, 5'd0};
        tbl[12] = '{41,   1'b1, 1'b0, 1'b1, 5'd0};
        tbl[13] = '{44,   1'b1, 1'b0, 1'b1, 5'd0};
        tbl[14] = '{45,   1'b1, 1'b0, 1'b0, 5'd0};
        tbl[15] = '{524,  1'b1, 1'b0, 1'b1, 5'd0};
        tbl[16] = '{525,  1'b1, 1'b0, 1'b1, 5'd1};
        tbl[17] = '{528,  1'b1, 1'b0, 1'b1, 5'd1};
        tbl[18] = '{529,  1'b1, 1'b0, 1'b0, 5'd1};
        tbl[19] = '{1048, 1'b1, 1'b0, 1'b1, 5'd1};
        tbl[20] = '{1049, 1'b0, 1'b1, 1'b1, 5'd0};
        tbl[21] = '{1050, 1'b0, 1'b0, 1'b1, 5'd0};

        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regs_a[i] = '0;
            regs_b[i] = '0;
        end
        rst = 1'b1;

        // ---- reset and idle ----
        repeat (3) @(negedge clk);
        check("reset_state_a", {busy_a, done_a, tx_a, regAddr_a}, {1'b0, 1'b0, 1'b1, 5'd0});
        check("reset_state_b", {busy_b, done_b, tx_b, regAddr_b}, {1'b0, 1'b0, 1'b1, 5'd0});
        rst   = 1'b0;
        bad_a = 0;
        bad_b = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || regAddr_a !== 5'd0) bad_a++;
            if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0 || regAddr_b !== 5'd0) bad_b++;
        end
        check("idle_cycles_bad_a", bad_a, 0);
        check("idle_cycles_bad_b", bad_b, 0);

        // ---- two-register dump, cycle-exact vectors ----
        regs_a[0] = 32'h0000_0000;
        regs_a[1] = 32'hDEAD_BEEF;
        build_exp(0);
        rx_a.delete();
        done_cnt_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        cyc = 0;
        ti  = 0;
        while (cyc < 1050) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            while (ti < NV && tbl[ti].cyc == cyc) begin
                check($sformatf("vec_cycle_%0d {busy,done,tx,addr}", cyc),
                      {busy_a, done_a, tx_a, regAddr_a},
                      {tbl[ti].busy, tbl[ti].done, tbl[ti].tx, tbl[ti].addr});
                ti++;
            end
        end
        repeat (5) @(negedge clk);
        cmp_stream("dump_a_text", 0);
        check("done_pulses_a", done_cnt_a, 1);

        // ---- start on the done cycle is ignored; next start is taken ----
        pulse_start(0);
        wait_done(0, 1200, cyc);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("start_on_done_busy", busy_a, 0);
        repeat (20) @(negedge clk);
        check("start_on_done_idle {busy,tx}", {busy_a, tx_a}, 2'b01);
        pulse_start(0);
        check("restart_busy", busy_a, 1);
        wait_done(0, 1200, cyc);
        repeat (5) @(negedge clk);

        // ---- full 32-register dump with cycle budget ----
        for (int i = 0; i < 32; i++) regs_b[i] = i * 32'h0101_0101;
        build_exp(1);
        rx_b.delete();
        done_cnt_b = 0;
        max_addr_b = 0;
        pulse_start(1);
        wait_done(1, 13000, cyc);
        tot = RC_B * (SET + 2 + 13 * 10 * BAUD_B);
        tests++;
        if (cyc < tot - 2 || cyc > tot + 2) begin
            fails++;
            $display("FAIL dump_b_cycles: got %0d required %0d +/-2", cyc, tot);
        end
        check("done_with_busy_low", busy_b, 0);
        check("addr_at_done", regAddr_b, 0);
        repeat (5) @(negedge clk);
        cmp_stream("dump_b_text", 1);
        s31 = "1F:1F1F1F1F";
        bad_b = 0;
        if (rx_b.size() < 13 * 32) bad_b = 1;
        else begin
            for (int k = 0; k < 11; k++) if (rx_b[13 * 31 + k] !== s31[k]) bad_b = 1;
            if (rx_b[13 * 31 + 11] !== 8'h0D || rx_b[13 * 31 + 12] !== 8'h0A) bad_b = 1;
        end
        check("line31_text_bad", bad_b, 0);
        check("max_addr_b", max_addr_b, 31);
        check("done_pulses_b", done_cnt_b, 1);

        // ---- random data; regData change mid-line and start while busy ----
        for (int i = 0; i < 32; i++) regs_b[i] = $urandom;
        build_exp(1);
        rx_b.delete();
        done_cnt_b = 0;
        pulse_start(1);
        wait_rx(5 * 13 + 4, 3000);
        check("mid_line5_addr", regAddr_b, 5);
        regs_b[5] = ~regs_b[5];
        start_b   = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1, 13000, cyc);
        repeat (200) @(negedge clk);
        cmp_stream("dump_b_latched_text", 1);
        check("done_pulses_busy_start", done_cnt_b, 1);
        check("idle_after_dump {busy,tx}", {busy_b, tx_b}, 2'b01);

        // ---- asynchronous reset during data bit 3 of line 2 ----
        for (int i = 0; i < 32; i++) regs_b[i] = $urandom;
        build_exp(1);
        rx_b.delete();
        pulse_start(1);
        wait_rx(2 * 13, 1500);
        cyc = 0;
        while (tx_b !== 1'b0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4 * BAUD_B + 1) @(negedge clk);
        check("tx_in_bit3_before_reset", tx_b, 0);
        rst = 1'b1;
        #1;
        check("async_reset {busy,done,tx,addr}", {busy_b, done_b, tx_b, regAddr_b},
              {1'b0, 1'b0, 1'b1, 5'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx_b.delete();
        done_cnt_b = 0;
        pulse_start(1);
        wait_done(1, 13000, cyc);
        repeat (5) @(negedge clk);
        cmp_stream("dump_after_reset_text", 1);
        check("done_pulses_after_reset", done_cnt_b, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
